// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps a bank of 74352-style inverting muxes through
// every input, re-inverts the sampled Y_bar lines and publishes one parallel
// word per block with a Busy/Done handshake.
module mux_scan_sequencer #(
    parameter int BLOCKS       = 2,
    parameter int WIDTH_IN     = 4,
    parameter int WIDTH_SELECT = $clog2(WIDTH_IN),
    parameter int DELAY_RISE   = 0,
    parameter int DELAY_FALL   = 0
) (
    input  logic                       Clk,
    input  logic                       Clear_bar,
    input  logic                       Start,
    input  logic                       Continuous,
    input  logic [BLOCKS-1:0]          Y_bar_in,
    output logic [WIDTH_SELECT-1:0]    Select,
    output logic [BLOCKS-1:0]          Enable_bar,
    output logic [WIDTH_IN*BLOCKS-1:0] Data_2D,
    output logic                       Busy,
    output logic                       Done
);

    // Output delays are a board-level timing budget (mux path plus delays
    // must fit in one clock); they have no RTL representation, only a
    // sanity check on the configuration.
    if (WIDTH_IN < 2 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_cfg
        $error("mux_scan_sequencer: WIDTH_IN must be >= 2 and delays >= 0");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [WIDTH_SELECT-1:0] LAST_SEL = WIDTH_SELECT'(WIDTH_IN - 1);

    state_t                       state_q,  state_d;
    logic [WIDTH_SELECT-1:0]      select_q, select_d;
    logic [WIDTH_IN*BLOCKS-1:0]   shadow_q, shadow_d;
    logic [WIDTH_IN*BLOCKS-1:0]   data_q,   data_d;
    logic                         done_q,   done_d;

    // State, select counter, shadow and published word registers
    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            state_q  <= IDLE;
            select_q <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    // Next-state: accept Start in IDLE, sample one mux input per step in SCAN
    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                select_d = '0;
                if (Start) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                for (int unsigned b = 0; b < BLOCKS; b++) begin
                    shadow_d[b*WIDTH_IN + int'(select_q)] = ~Y_bar_in[b];
                end
                if (select_q == LAST_SEL) begin
                    // Publish the shadow with this edge's bits already merged
                    data_d   = shadow_d;
                    done_d   = 1'b1;
                    select_d = '0;
                    state_d  = Continuous ? SCAN : IDLE;
                end else begin
                    select_d = select_q + WIDTH_SELECT'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        Busy       = (state_q == SCAN);
        Enable_bar = (state_q == SCAN) ? '0 : '1;
        Select     = select_q;
        Data_2D    = data_q;
        Done       = done_q;
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Testbench for mux_scan_sequencer: behavioural 74352 mux model feeding the
// DUT, table-driven single scans plus directed multi-cycle sequences.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       clear_bar;
    logic       start, continuous;
    logic [3:0] a0, a1;
    logic [1:0] ybar;
    logic [1:0] sel;
    logic [1:0] en_bar;
    logic [7:0] data;
    logic       busy, done;

    // Second instance: WIDTH_IN=3, BLOCKS=1
    logic       start3;
    logic [3:0] a3;
    logic [0:0] ybar3;
    logic [1:0] sel3;
    logic [0:0] en_bar3;
    logic [2:0] data3;
    logic       busy3, done3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Inverting mux model
    assign ybar[0]  = ~a0[sel];
    assign ybar[1]  = ~a1[sel];
    assign ybar3[0] = ~a3[sel3];

    mux_scan_sequencer dut (
        .Clk        (clk),
        .Clear_bar  (clear_bar),
        .Start      (start),
        .Continuous (continuous),
        .Y_bar_in   (ybar),
        .Select     (sel),
        .Enable_bar (en_bar),
        .Data_2D    (data),
        .Busy       (busy),
        .Done       (done)
    );

    mux_scan_sequencer #(.BLOCKS(1), .WIDTH_IN(3)) dut3 (
        .Clk        (clk),
        .Clear_bar  (clear_bar),
        .Start      (start3),
        .Continuous (1'b0),
        .Y_bar_in   (ybar3),
        .Select     (sel3),
        .Enable_bar (en_bar3),
        .Data_2D    (data3),
        .Busy       (busy3),
        .Done       (done3)
    );

    typedef struct {
        logic [3:0] a0;
        logic [3:0] a1;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Pulse Start for one edge and count edges until Done (bounded)
    task automatic run_scan(output int cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int         n, idle, ndone;
        logic [7:0] prev;

        vecs[0] = '{a0: 4'b1010, a1: 4'b0110, exp: 8'h6A};
        vecs[1] = '{a0: 4'b0001, a1: 4'b0110, exp: 8'h61};
        vecs[2] = '{a0: 4'b1111, a1: 4'b0000, exp: 8'h0F};
        vecs[3] = '{a0: 4'b0000, a1: 4'b1111, exp: 8'hF0};
        vecs[4] = '{a0: 4'b0101, a1: 4'b1001, exp: 8'h95};

        clear_bar  = 1'b0;
        start      = 1'b0;
        start3     = 1'b0;
        continuous = 1'b0;
        a0 = '0; a1 = '0; a3 = 4'b0101;
        #1;
        chk("rst_sel",  32'(sel),    32'h0);
        chk("rst_en",   32'(en_bar), 32'h3);
        chk("rst_busy", 32'(busy),   32'h0);
        chk("rst_done", 32'(done),   32'h0);
        chk("rst_data", 32'(data),   32'h0);
        @(negedge clk);
        clear_bar = 1'b1;
        @(negedge clk);

        // Table-driven single scans
        prev = 8'h00;
        for (int i = 0; i < 5; i++) begin
            a0 = vecs[i].a0;
            a1 = vecs[i].a1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("acc_busy", 32'(busy),   32'h1);
            chk("acc_en",   32'(en_bar), 32'h0);
            chk("acc_sel",  32'(sel),    32'h0);
            chk("hold",     32'(data),   32'(prev));
            n = 0;
            while (n < 20) begin
                @(negedge clk);
                n++;
                if (done === 1'b1) break;
                chk("seq_sel", 32'(sel),  32'(n));
                chk("partial", 32'(data), 32'(prev));
            end
            chk("latency",   32'(n),      32'h4);
            chk("data",      32'(data),   32'(vecs[i].exp));
            chk("end_busy",  32'(busy),   32'h0);
            chk("end_en",    32'(en_bar), 32'h3);
            @(negedge clk);
            chk("done_1clk", 32'(done),   32'h0);
            chk("post_hold", 32'(data),   32'(vecs[i].exp));
            prev = vecs[i].exp;
        end

        // Continuous: zero gap, second word 4 clocks later
        a0 = 4'b1010; a1 = 4'b0110;
        continuous = 1'b1;
        run_scan(n);
        chk("cont_lat1",  32'(n),    32'h4);
        chk("cont_data1", 32'(data), 32'h6A);
        chk("cont_busy",  32'(busy), 32'h1);
        a0 = 4'b0001;
        continuous = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) break;
            chk("cont_busy_mid", 32'(busy), 32'h1);
        end
        chk("cont_lat2",  32'(n),    32'h4);
        chk("cont_data2", 32'(data), 32'h61);
        chk("cont_idle",  32'(busy), 32'h0);
        @(negedge clk);

        // Asynchronous reset mid-scan
        a0 = 4'b1010; a1 = 4'b0110;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (sel !== 2'd2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("reach_sel2", 32'(sel), 32'h2);
        #2;
        clear_bar = 1'b0;
        #1;
        chk("mid_rst_data", 32'(data),   32'h0);
        chk("mid_rst_en",   32'(en_bar), 32'h3);
        chk("mid_rst_busy", 32'(busy),   32'h0);
        chk("mid_rst_sel",  32'(sel),    32'h0);
        chk("mid_rst_done", 32'(done),   32'h0);
        @(negedge clk);
        clear_bar = 1'b1;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("rst_no_done", 32'(ndone), 32'h0);
        chk("rst_data0",   32'(data),  32'h0);
        run_scan(n);
        chk("after_rst_lat",  32'(n),    32'h4);
        chk("after_rst_data", 32'(data), 32'h6A);
        @(negedge clk);

        // Start held high: Done every 5 cycles with one idle cycle between
        start = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("held_first", 32'(n), 32'h5);
        n = 0; idle = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (en_bar === 2'b11) idle++;
            if (done === 1'b1) break;
        end
        start = 1'b0;
        chk("held_period", 32'(n),    32'h5);
        chk("held_idle",   32'(idle), 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("held_stop", 32'(busy), 32'h0);

        // Start pulsed during SCAN is ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (sel !== 2'd1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ign_sel1", 32'(sel), 32'h1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        repeat (15) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        chk("ign_ndone", 32'(ndone), 32'h1);
        chk("ign_busy",  32'(busy),  32'h0);

        // WIDTH_IN=3, BLOCKS=1
        chk("w3_rst_data", 32'(data3), 32'h0);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        chk("w3_sel0", 32'(sel3),  32'h0);
        chk("w3_busy", 32'(busy3), 32'h1);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            chk("w3_sel",  32'(sel3),  32'(k));
            chk("w3_ndone", 32'(done3), 32'h0);
        end
        @(negedge clk);
        chk("w3_done",  32'(done3),   32'h1);
        chk("w3_data",  32'(data3),   32'h5);
        chk("w3_wrap",  32'(sel3),    32'h0);
        chk("w3_en",    32'(en_bar3), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream controller for a 74352-style dual 4-input inverting multiplexer.
- Drives the mux Select and Enable_bar lines and steps Select through every input.
- Samples the mux Y_bar outputs on each step, re-inverts them, and assembles one full parallel word per block.
- Presents the word with a Busy/Done handshake, so a bank of mux inputs can be read serially through a narrow mux.

Parameters:
BLOCKS, 2, number of mux blocks scanned in parallel (one Y_bar bit per block)
WIDTH_IN, 4, inputs per mux block; scan length in clocks; any value >= 2, need not be a power of two
WIDTH_SELECT, $clog2(WIDTH_IN), width of Select
DELAY_RISE, 0, rise delay applied to all outputs
DELAY_FALL, 0, fall delay applied to all outputs

Ports:
Clk  input  1  clock; all state changes on the rising edge
Clear_bar  input  1  asynchronous, active-low reset
Start  input  1  request a scan; sampled on a rising edge while idle
Continuous  input  1  when 1 at the last scan step, start a new scan immediately
Y_bar_in  input  BLOCKS  inverted mux outputs, one per block
Select  output  WIDTH_SELECT  mux select to the mux stage
Enable_bar  output  BLOCKS  active-low mux enables; all blocks share one value
Data_2D  output  WIDTH_IN*BLOCKS  captured word; block b at bits [b*WIDTH_IN +: WIDTH_IN], bit s = mux input s
Busy  output  1  high while a scan is in progress
Done  output  1  one-clock pulse when Data_2D has just been updated

Behaviour:
Interface:
- One clock; reset is asynchronous and active-low.
- Clock port is Clk; reset port is Clear_bar.

Reset:
- Clear_bar low forces, immediately and regardless of Clk: state IDLE, Select=0, Enable_bar=all 1, Busy=0, Done=0, Data_2D=0, shadow register=0.
- Reset mid-scan abandons the scan; no Done pulse; Data_2D reads 0.

States:
- IDLE: Enable_bar=all 1, Select=0, Busy=0.
  - Rising edge with Start=1 -> SCAN, with Select=0 and Enable_bar=all 0.
- SCAN: Enable_bar=all 0, Busy=1.
  - Each rising edge: shadow[b*WIDTH_IN+Select] <= ~Y_bar_in[b] for every b.
  - If Select < WIDTH_IN-1: Select <= Select+1.
  - If Select == WIDTH_IN-1: Data_2D <= shadow with the final bits merged in the same edge, and Done <= 1 for exactly one cycle. Then:
    - Continuous=1: stay in SCAN, Select <= 0, Busy stays 1.
    - Continuous=0: go to IDLE, Select <= 0, Enable_bar <= all 1, Busy <= 0.

Timing:
- Y_bar_in is sampled one full clock after Select changes. The mux path delay plus DELAY_RISE/DELAY_FALL must be less than one clock period.
- Latency: Done is high in the cycle beginning exactly WIDTH_IN rising edges after the edge that accepted Start.
- Data_2D changes only on the Done edge; partial results never appear on it.
- Data_2D holds its value through IDLE and through the next scan until that scan's Done.

Handshake rules:
- Start is ignored while in SCAN, including at the last step; only Continuous extends a scan.
- A Start held high in IDLE is accepted on the first edge, including the edge on which Done is high. Back-to-back scans then have a one-cycle IDLE gap; Continuous gives zero gap.
- Select never exceeds WIDTH_IN-1, e.g. for WIDTH_IN=3 it runs 0,1,2,0.

Test Plan:
- BLOCKS=2, WIDTH_IN=4; bench mux model with A0=4'b1010, A1=4'b0110 drives Y_bar_in; pulse Start one cycle -> Select sequence 0,1,2,3; Busy high 4 cycles; Done high for 1 cycle at edge 4 after acceptance; Data_2D=8'h6A.
- Same setup with Continuous=1, then A0 changed to 4'b0001 during the second scan -> no idle gap; first Done gives 8'h6A, second Done gives 8'h61 exactly 4 clocks later; Busy never drops.
- Assert Clear_bar low at Select=2 mid-scan -> immediately Data_2D=0, Enable_bar=2'b11, Busy=0, Select=0; no Done. After release, the next Start scan completes normally.
- Start held high continuously with Continuous=0 -> Done every 5 cycles; Enable_bar=2'b11 for exactly one cycle between scans.
- WIDTH_IN=3, BLOCKS=1, A=3'b101 -> Select 0,1,2 then back to 0; Done after 3 edges; Data_2D=3'b101.
- Start pulsed during SCAN at Select=1 -> ignored: one Done only, no extra scan.
